// File: rtl/regfile_operand_stage_if.sv
// Handshake and data bundle between decode, the operand-fetch stage and the ALU.
// The master drives requests, write-back and out_ready. The slave (the stage) drives the rest.
interface regfile_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd_in;
  logic [OP_W-1:0]   op_in;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ADDR_W-1:0] rd_out;
  logic [OP_W-1:0]   op_out;

  modport master (
    output in_valid, rs1, rs2, rd_in, op_in, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, a, b, rd_out, op_out
  );

  modport slave (
    input  in_valid, rs1, rs2, rd_in, op_in, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, a, b, rd_out, op_out
  );
endinterface

// File: rtl/regfile_operand_stage.sv
// Operand-fetch stage: a 16-entry register file with write-back bypass on both read ports.
// Its outputs feed a single-entry valid/ready pipeline register toward the ALU.
module regfile_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_operand_stage_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_rd;
  logic [OP_W-1:0]   r_op;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_wb_live;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // A write to r0 is dropped everywhere, including the bypass.
  assign w_wb_live  = bus.wb_en && (bus.wb_addr != '0);
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_rd_a = (bus.rs1 == '0)                         ? '0          :
                  (w_wb_live && bus.wb_addr == bus.rs1)   ? bus.wb_data :
                                                            r_rf[bus.rs1];
  assign w_rd_b = (bus.rs2 == '0)                         ? '0          :
                  (w_wb_live && bus.wb_addr == bus.rs2)   ? bus.wb_data :
                                                            r_rf[bus.rs2];

  // NOTE: the register file sits under the async reset on purpose, because every entry must read as zero after reset.
  // That rules out a RAM macro here, which is acceptable at 16 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wb_live) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Held operands capture their values at accept and ignore later write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_op        <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_a         <= w_rd_a;
      r_b         <= w_rd_b;
      r_rd        <= bus.rd_in;
      r_op        <= bus.op_in;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.rd_out    = r_rd;
  assign bus.op_out    = r_op;
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  regfile_operand_stage_if #(.DATA_W(32), .ADDR_W(4), .OP_W(4)) bus ();

  regfile_operand_stage #(.DATA_W(32), .ADDR_W(4), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: an array of register values and one output slot.
  logic [31:0] m_rf [16];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_rd, m_op;

  function automatic logic [31:0] mread(input logic [3:0] x);
    if (x == 4'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == x) return bus.wb_data;
    return m_rf[x];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] <= 32'd0;
      m_valid <= 1'b0;
      m_a <= 32'd0; m_b <= 32'd0; m_rd <= 4'd0; m_op <= 4'd0;
    end else begin
      if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid <= 1'b1;
        m_a  <= mread(bus.rs1);
        m_b  <= mread(bus.rs2);
        m_rd <= bus.rd_in;
        m_op <= bus.op_in;
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
      if (bus.wb_en && bus.wb_addr != 4'd0) m_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      check("cyc out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("cyc a", bus.a, m_a);
        check("cyc b", bus.b, m_b);
        check("cyc rd_out", 32'(bus.rd_out), 32'(m_rd));
        check("cyc op_out", 32'(bus.op_out), 32'(m_op));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit v, input logic [3:0] r1, input logic [3:0] r2,
                     input logic [3:0] rd, input logic [3:0] op);
    bus.in_valid = v; bus.rs1 = r1; bus.rs2 = r2; bus.rd_in = rd; bus.op_in = op;
  endtask

  task automatic wb(input bit en, input logic [3:0] ad, input logic [31:0] d);
    bus.wb_en = en; bus.wb_addr = ad; bus.wb_data = d;
  endtask

  initial begin
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    wb(1'b0, 4'd0, 32'd0);
    bus.out_ready = 1'b1;
    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset a", bus.a, 32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: reset then read
    req(1'b1, 4'd5, 4'd9, 4'd1, 4'd2);
    #1 check("t1 in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t1 out_valid", 32'(bus.out_valid), 32'd1);
    check("t1 a", bus.a, 32'd0);
    check("t1 b", bus.b, 32'd0);
    check("t1 in_ready", 32'(bus.in_ready), 32'd1);
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    // 2: write then read
    wb(1'b1, 4'd3, 32'hA5A5_0F0F);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    req(1'b1, 4'd3, 4'd0, 4'd4, 4'd5);
    tick();
    check("t2 a", bus.a, 32'hA5A5_0F0F);
    check("t2 b", bus.b, 32'd0);
    check("t2 model a", m_a, 32'hA5A5_0F0F);
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    // 3: same-cycle bypass, then an ignored r0 write
    wb(1'b1, 4'd7, 32'h1111_1111);
    tick();
    wb(1'b1, 4'd7, 32'hDEAD_BEEF);
    req(1'b1, 4'd7, 4'd7, 4'd7, 4'd1);
    tick();
    check("t3 a bypass", bus.a, 32'hDEAD_BEEF);
    check("t3 b bypass", bus.b, 32'hDEAD_BEEF);
    check("t3 model b", m_b, 32'hDEAD_BEEF);
    wb(1'b1, 4'd0, 32'hFFFF_FFFF);
    req(1'b1, 4'd0, 4'd7, 4'd0, 4'd2);
    tick();
    check("t3 a r0", bus.a, 32'd0);
    check("t3 b r7", bus.b, 32'hDEAD_BEEF);
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    // 4: backpressure holds operands despite write-backs
    wb(1'b1, 4'd2, 32'h0000_00F0);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    bus.out_ready = 1'b0;
    req(1'b1, 4'd2, 4'd0, 4'd9, 4'd3);
    tick();
    check("t4 accept a", bus.a, 32'h0000_00F0);
    req(1'b1, 4'd4, 4'd4, 4'd4, 4'd4);
    wb(1'b1, 4'd2, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 hold a", bus.a, 32'h0000_00F0);
      check("t4 hold rd_out", 32'(bus.rd_out), 32'd9);
      check("t4 hold in_ready", 32'(bus.in_ready), 32'd0);
      check("t4 hold out_valid", 32'(bus.out_valid), 32'd1);
    end
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    wb(1'b0, 4'd0, 32'd0);
    bus.out_ready = 1'b1;
    #1 check("t4 release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t4 drained", 32'(bus.out_valid), 32'd0);

    // 5: streaming, one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      req(1'b1, 4'(i), 4'(9 - i), 4'(i), 4'(16 - i));
      tick();
      check("t5 out_valid", 32'(bus.out_valid), 32'd1);
      check("t5 rd_out", 32'(bus.rd_out), 32'(i));
      check("t5 op_out", 32'(bus.op_out), 32'(16 - i));
    end
    check("t5 last a r8", bus.a, 32'd0);
    check("t5 last b r1", bus.b, 32'd0);
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    check("t5 drained", 32'(bus.out_valid), 32'd0);

    // 6: async reset during a hold
    bus.out_ready = 1'b0;
    req(1'b1, 4'd7, 4'd3, 4'd6, 4'd6);
    tick();
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    check("t6 pre a", bus.a, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", 32'(bus.out_valid), 32'd0);
    check("t6 rst a", bus.a, 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("t6 no change after release", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    req(1'b1, 4'd3, 4'd7, 4'd1, 4'd1);
    tick();
    check("t6 r3 cleared", bus.a, 32'd0);
    check("t6 r7 cleared", bus.b, 32'd0);
    req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Randomized traffic, checked each cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      wb(1'($urandom_range(0, 1)),
         ($urandom_range(0, 2) == 0) ? bus.rs1 : 4'($urandom_range(0, 15)), $urandom);
      tick();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_operand_stage.md
Name: regfile_operand_stage

Overview:
- Operand-fetch stage feeding the 32-bit ALU logic units, such as bitwise OR/AND/XOR.
- Holds a 16 x 32 register file with two read ports and one write-back port.
- Registers the two read operands, plus destination register and opcode, into a single-entry pipeline register with a valid/ready handshake.
- Write-back data is bypassed into same-cycle reads, so the ALU always sees current values.

Parameters:
- DATA_W, 32, operand/register width.
- ADDR_W, 4, register address width; register file depth = 2**ADDR_W (16).
- OP_W, 4, opcode width carried alongside operands.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream (decode) presents a request.
- in_ready  output  1  stage can accept a request this cycle.
- rs1  input  ADDR_W  source register for operand a.
- rs2  input  ADDR_W  source register for operand b.
- rd_in  input  ADDR_W  destination register, passed through.
- op_in  input  OP_W  ALU opcode, passed through.
- wb_en  input  1  write-back enable.
- wb_addr  input  ADDR_W  write-back register address.
- wb_data  input  DATA_W  write-back data.
- out_valid  output  1  registered operands valid toward the ALU.
- out_ready  input  1  ALU/downstream accepts the operands.
- a  output  DATA_W  operand a.
- b  output  DATA_W  operand b.
- rd_out  output  ADDR_W  registered destination.
- op_out  output  OP_W  registered opcode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; a, b, rd_out and op_out = 0.
  - All 16 registers cleared to 0.
  - Effective immediately, and still in force after rst_n deasserts, until the first clk edge.
- Register 0:
  - Reads always return 0.
  - Writes with wb_addr=0 are ignored, including the bypass path.
- in_ready = !out_valid || out_ready. This is combinational, and in_ready must not depend on in_valid.
- Accept:
  - Occurs when in_valid && in_ready at a rising edge.
  - Next cycle: out_valid=1, a=read(rs1), b=read(rs2), rd_out=rd_in, op_out=op_in.
  - Latency is 1 cycle.
- Read with bypass: read(x) = (wb_en && wb_addr==x && x!=0) ? wb_data : RF[x]. This applies to both ports independently, and to rs1==rs2.
- Write-back:
  - RF[wb_addr] <= wb_data at every edge where wb_en=1 and wb_addr!=0.
  - Independent of the in/out handshake; never stalls.
- Hold (out_valid && !out_ready):
  - a, b, rd_out, op_out and out_valid remain stable; in_ready=0.
  - Held operands are NOT refreshed by later write-backs. RAW hazards across a stall are the issuer's responsibility.
- Drain: out_ready=1 with no accept in the same cycle -> out_valid=0 next cycle. a, b, rd_out and op_out keep their last values (don't-care).
- Simultaneous drain and accept (out_valid && out_ready && in_valid): new operands load next cycle and out_valid stays 1. Sustains 1 transfer/cycle with no bubble.
- Reset mid-operation:
  - Any held transfer is dropped; out_valid=0.
  - Register contents are lost (zeroed).
  - No output change is permitted on the first edge after release unless an accept occurs.
- No overflow or arithmetic is performed here; widths pass through unchanged.

Test Plan:
1. Reset then read: after rst_n release, accept rs1=5, rs2=9 -> next cycle out_valid=1, a=0, b=0; in_ready=1 throughout.
2. Write then read: wb_en=1, wb_addr=3, wb_data=32'hA5A5_0F0F, then accept rs1=3, rs2=0 in the following cycle -> a=32'hA5A5_0F0F, b=0.
3. Same-cycle bypass: RF[7]=32'h1111_1111; in the same cycle, wb_en=1 to addr 7 with 32'hDEAD_BEEF and accept rs1=7, rs2=7 -> a=b=32'hDEAD_BEEF. Repeat with wb_addr=0 and data 32'hFFFF_FFFF, reading rs1=0 -> a=0.
4. Backpressure: accept rs1=2 (RF[2]=32'h0000_00F0), hold out_ready=0 for 3 cycles while writing RF[2]=32'h0000_000F -> a stays 32'h0000_00F0, in_ready=0, out_valid=1. Release out_ready -> transfer completes and in_ready=1.
5. Streaming: in_valid=1 and out_ready=1 for 8 cycles with rs1=1..8 -> 8 consecutive output beats with no bubble, in order, rd_out/op_out matching the inputs.
6. Async reset mid-hold: out_valid=1 and stalled, assert rst_n=0 between clock edges -> out_valid=0 and a=0 immediately (before the next edge); subsequent reads of any register return 0.
